stable_filter: RTL and testbench

//   Qualification stage that sits directly downstream of delay2. It watches the

---
 rtl/stable_filter.sv | 108 ++++++++++
 tb/tb_stable_filter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/stable_filter.sv
// Debounce/qualification stage: a value is accepted once it has been sampled on
// N consecutive edges, then offered once over a single-entry valid/ready slot.
module stable_filter #(
    parameter int N = 3,
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_in,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_busy,
    output logic         o_overrun
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [W-1:0]  r_held;
    logic [W-1:0]  r_cand;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_data;
    logic          r_valid;
    logic          r_overrun;

    logic [W-1:0]  w_cand_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_accept;
    logic [W-1:0]  w_acc_val;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    // A return to the held value is a rejected glitch, not a new candidate.
    always_comb begin
        w_next_state = r_state;
        w_cand_nxt   = r_cand;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_acc_val    = i_in;
        case (r_state)
            IDLE: begin
                if (i_in != r_held) begin
                    if (N == 1) begin
                        w_accept = 1'b1;
                    end else begin
                        w_next_state = COUNT;
                        w_cand_nxt   = i_in;
                        w_cnt_nxt    = CW'(1);
                    end
                end
            end
            COUNT: begin
                if (i_in == r_cand) begin
                    if (r_cnt == CW'(N - 1)) begin
                        w_accept     = 1'b1;
                        w_acc_val    = r_cand;
                        w_next_state = IDLE;
                    end else if (r_cnt < CW'(N)) begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else if (i_in == r_held) begin
                    w_next_state = IDLE;
                end else begin
                    w_cand_nxt = i_in;
                    w_cnt_nxt  = CW'(1);
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_busy    = (r_state == COUNT);
        o_data    = r_data;
        o_valid   = r_valid;
        o_overrun = r_overrun;
    end

    // An accept always wins the slot; it only counts as an overrun if the old
    // value was still pending and not taken on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_held    <= '0;
            r_cand    <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_accept) begin
                r_held  <= w_acc_val;
                r_data  <= w_acc_val;
                r_valid <= 1'b1;
                if (r_valid && !i_ready) r_overrun <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stable_filter.sv
// Bench for stable_filter: an N=3 and an N=1 instance share stimulus and are
// checked every edge against a run-length model of the acceptance rule.
module tb_stable_filter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         rdy;

    logic [W-1:0] d3, d1;
    logic         v3, v1, b3, b1, ov3, ov1;

    int n_cmp = 0;
    int n_err = 0;

    // Model state, index 0 = N=3 instance, index 1 = N=1 instance.
    int           mn   [2] = '{3, 1};
    logic [W-1:0] m_held[2], m_data[2], m_rv[2];
    int           m_rlen[2];
    logic         m_valid[2], m_busy[2], m_ovr[2];

    always #5 clk = ~clk;

    stable_filter #(.N(3), .W(W)) u3 (
        .i_clk(clk), .i_reset(rst), .i_in(din), .i_ready(rdy),
        .o_data(d3), .o_valid(v3), .o_busy(b3), .o_overrun(ov3)
    );

    stable_filter #(.N(1), .W(W)) u1 (
        .i_clk(clk), .i_reset(rst), .i_in(din), .i_ready(rdy),
        .o_data(d1), .o_valid(v1), .o_busy(b1), .o_overrun(ov1)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A value is accepted when the last N samples all equal it and it differs
    // from the last accepted value; a non-held input means qualification is pending.
    task automatic model(input int m);
        logic acc;
        if (rst) begin
            m_held[m] = '0; m_data[m] = '0; m_valid[m] = 1'b0;
            m_ovr[m] = 1'b0; m_busy[m] = 1'b0; m_rlen[m] = 0; m_rv[m] = '0;
        end else begin
            if (m_rlen[m] > 0 && din == m_rv[m]) begin
                if (m_rlen[m] < 1000) m_rlen[m]++;
            end else begin
                m_rv[m] = din;
                m_rlen[m] = 1;
            end
            acc = (m_rlen[m] >= mn[m]) && (din != m_held[m]);
            if (acc) begin
                if (m_valid[m] && !rdy) m_ovr[m] = 1'b1;
                m_data[m] = din; m_held[m] = din; m_valid[m] = 1'b1;
            end else if (m_valid[m] && rdy) begin
                m_valid[m] = 1'b0;
            end
            m_busy[m] = (din != m_held[m]);
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] v, input logic rd);
        rst = r; din = v; rdy = rd;
        @(posedge clk);
        model(0);
        model(1);
        #1;
        chk("n3_data",    d3,        m_data[0]);
        chk("n3_valid",   W'(v3),    W'(m_valid[0]));
        chk("n3_busy",    W'(b3),    W'(m_busy[0]));
        chk("n3_overrun", W'(ov3),   W'(m_ovr[0]));
        chk("n1_data",    d1,        m_data[1]);
        chk("n1_valid",   W'(v1),    W'(m_valid[1]));
        chk("n1_busy",    W'(b1),    W'(m_busy[1]));
        chk("n1_overrun", W'(ov1),   W'(m_ovr[1]));
    endtask

    initial begin
        rst = 1'b1; din = 4'd5; rdy = 1'b0;
        // 1: reset with non-zero input, then qualify 5
        repeat (4) step(1'b1, 4'd5, 1'b0);
        chk("reset_valid", W'(v3), '0);
        step(1'b0, 4'd5, 1'b0);
        chk("t1_busy_e1", W'(b3), W'(1));
        step(1'b0, 4'd5, 1'b0);
        step(1'b0, 4'd5, 1'b0);
        chk("t1_data_e3", d3, 4'd5);
        chk("t1_valid_e3", W'(v3), W'(1));
        // 2: glitch of 2 clocks rejected, consumer drains 5
        step(1'b0, 4'd9, 1'b1);
        step(1'b0, 4'd9, 1'b1);
        step(1'b0, 4'd5, 1'b1);
        step(1'b0, 4'd5, 1'b1);
        chk("t2_data", d3, 4'd5);
        // 3: short 1 then steady 2
        step(1'b0, 4'd1, 1'b1);
        step(1'b0, 4'd1, 1'b1);
        repeat (3) step(1'b0, 4'd2, 1'b0);
        chk("t3_data", d3, 4'd2);
        step(1'b0, 4'd2, 1'b1);
        // 4: overwrite without ready, then mid-COUNT reset
        repeat (3) step(1'b0, 4'd5, 1'b0);
        repeat (3) step(1'b0, 4'd3, 1'b0);
        chk("t4_overrun", W'(ov3), W'(1));
        step(1'b0, 4'd7, 1'b0);
        step(1'b1, 4'd7, 1'b0);
        chk("t4_reset_ovr", W'(ov3), '0);
        // 5: ready exactly on second accept edge
        repeat (3) step(1'b0, 4'd6, 1'b0);
        step(1'b0, 4'd8, 1'b0);
        step(1'b0, 4'd8, 1'b0);
        step(1'b0, 4'd8, 1'b1);
        chk("t5_data", d3, 4'd8);
        chk("t5_ovr", W'(ov3), '0);
        // 6: one-clock steps for the N=1 instance
        step(1'b1, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd4, 1'b1);
        chk("t6_data4", d1, 4'd4);
        step(1'b0, 4'd7, 1'b1);
        chk("t6_data7", d1, 4'd7);
        // random runs of random lengths, sparse resets
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] v;
            int len;
            v = W'($urandom_range(0, 3));
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++)
                step(($urandom_range(0, 59) == 0), v, 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
